output_drain: RTL and testbench

- Read-side counterpart of the output accumulation block.
- Once a layer's partial sums are fully accumulated in the output BRAM, this block walks a contiguous address range on BRAM port B and streams each word out over a valid/ready interface (to the next layer or host).
- Optionally writes zero behind every read, so the BRAM is ready for the next accumulation pass.
- Absorbs the BRAM's 1-cycle read latency and downstream backpressure with a small credit-controlled FIFO.

---
 rtl/output_drain.sv | 173 +++++++++++++++++
 tb/tb_output_drain.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/output_drain.sv
// -----------------------------------------------------------------------------
// output_drain
//   Walks a contiguous address range on output BRAM port B and streams each
//   word out on a valid/ready interface. It can optionally write zero behind
//   every read so the BRAM is ready for the next accumulation pass. A small
//   credit-controlled FIFO absorbs the 1-cycle BRAM read latency and
//   downstream backpressure.
//
//   Build option: define OUTPUT_DRAIN_RELU_EN to pass the FIFO-head word
//   through a ReLU before it reaches m_data_o. The FIFO always holds raw data.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i          start pulse, only honoured in IDLE
//   base_addr_i      first address, latched with start_i
//   count_i          word count, latched with start_i (0 = immediate done)
//   clear_i          zero-behind-read enable, latched with start_i
//   busy_o           high from the cycle after start until done_o
//   done_o           one-cycle completion pulse
//   bram_addr_o      port B address
//   bram_wr_en_o     port B write enable (write data is the constant 0)
//   bram_data_i      port B read data, one cycle after the address
//   m_valid_o/m_ready_i/m_data_o/m_last_o   output stream
//
// State | meaning
//   IDLE  | waiting for start_i
//   READ  | issuing reads, gated by FIFO credit
//   DRAIN | all reads issued, emptying FIFO until the last word leaves
//   DONE  | one-cycle completion pulse
// -----------------------------------------------------------------------------
module output_drain #(
    parameter int I_WIDTH         = 8,
    parameter int F_WIDTH         = 8,
    parameter int BRAM_ADDR_WIDTH = 11,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [BRAM_ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [BRAM_ADDR_WIDTH:0]     count_i,
    input  logic                         clear_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_addr_o,
    output logic                         bram_wr_en_o,
    input  logic [I_WIDTH+F_WIDTH-1:0]   bram_data_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [I_WIDTH+F_WIDTH-1:0]   m_data_o,
    output logic                         m_last_o
);

    localparam int D_W   = I_WIDTH + F_WIDTH;
    localparam int CNT_W = BRAM_ADDR_WIDTH + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [OCC_W:0]           DEPTH_L  = (OCC_W+1)'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]         OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0]         LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

    state_e                      state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0]  addr_q;
    logic [CNT_W-1:0]            remain_q;
    logic                        clear_q;
    logic                        inflight_q;
    logic                        inflight_last_q;

    logic [D_W-1:0]              fifo_data_q [FIFO_DEPTH];
    logic                        fifo_last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]            occ_q;

    logic                        pop;
    logic                        issue;
    logic                        final_issue;
    logic                        head_last;
    logic [D_W-1:0]              head_data;
    logic [OCC_W:0]              credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Slots already claimed: buffered words plus the read in flight, minus
    // the word leaving this cycle. Never negative since pop implies occ >= 1.
    assign m_valid_o   = (occ_q != '0);
    assign pop         = m_valid_o & m_ready_i;
    assign credit_used = {1'b0, occ_q} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
    assign head_data   = fifo_data_q[rd_ptr_q];
    assign head_last   = m_valid_o & fifo_last_q[rd_ptr_q];
    assign m_last_o    = head_last;
    assign bram_addr_o = addr_q;

`ifdef OUTPUT_DRAIN_RELU_EN
    assign m_data_o = head_data[D_W-1] ? '0 : head_data;
`else
    assign m_data_o = head_data;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = (count_i == '0) ? S_DONE : S_READ;
            S_READ:  if (final_issue) state_d = S_DRAIN;
            S_DRAIN: if (pop && head_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o       = (state_q != S_IDLE);
        done_o       = (state_q == S_DONE);
        issue        = (state_q == S_READ) && (credit_used < DEPTH_L);
        final_issue  = issue && (remain_q == CNT_ONE);
        bram_wr_en_o = issue && clear_q;
    end

    // Address / count tracking and read-latency pipeline
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q          <= '0;
            remain_q        <= '0;
            clear_q         <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                addr_q   <= base_addr_i;
                remain_q <= count_i;
                clear_q  <= clear_i;
            end else if (issue) begin
                addr_q   <= addr_q + ADDR_ONE;
                remain_q <= remain_q - CNT_ONE;
            end
            inflight_q      <= issue;
            inflight_last_q <= final_issue;
        end
    end

    // Skid FIFO; storage needs no reset because occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= bram_data_i;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (inflight_q && !pop)      occ_q <= occ_q + OCC_ONE;
            else if (!inflight_q && pop) occ_q <= occ_q - OCC_ONE;
        end
    end

endmodule

// File: tb/tb_output_drain.sv
module tb_output_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] count;
    logic        clear;
    logic        busy, done;
    logic [10:0] bram_addr;
    logic        bram_wr_en;
    logic [15:0] bram_rdata;
    logic        m_valid, m_ready, m_last;
    logic [15:0] m_data;

    logic [15:0] mem [2048];

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] got[$];
    logic        got_last[$];
    int wr_cnt, first_valid, done_cyc, stable_err, idle_busy;

    always #5 clk = ~clk;

    output_drain dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
        .count_i(count), .clear_i(clear), .busy_o(busy), .done_o(done),
        .bram_addr_o(bram_addr), .bram_wr_en_o(bram_wr_en),
        .bram_data_i(bram_rdata), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_data_o(m_data), .m_last_o(m_last)
    );

    // Read-first BRAM port B model
    always @(posedge clk) begin
        bram_rdata <= mem[bram_addr];
        if (bram_wr_en) mem[bram_addr] <= 16'h0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef OUTPUT_DRAIN_RELU_EN
        return w[15] ? 16'h0000 : w;
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] got_at(input int i);
        return (i < got.size()) ? {16'h0, got[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic int last_count();
        int n = 0;
        foreach (got_last[i]) if (got_last[i]) n++;
        return n;
    endfunction

    // mode 0: ready always high; mode 1: ready high every third cycle.
    // poke: pulse start_i (with a conflicting clear drain) mid-operation.
    task automatic drain(input logic [10:0] b, input logic [11:0] c, input logic clr,
                         input int mode, input bit poke);
        int cyc;
        bit stalled;
        logic [15:0] held_d;
        logic held_l;
        got.delete(); got_last.delete();
        wr_cnt = 0; first_valid = -1; done_cyc = -1; stable_err = 0;
        @(negedge clk);
        base_addr = b; count = c; clear = clr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; stalled = 0; held_d = '0; held_l = 1'b0;
        while (done_cyc < 0 && cyc < 200) begin
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (poke && cyc == 3) begin
                start = 1'b1; base_addr = 11'h7FE; count = 12'd2; clear = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1;
            if (bram_wr_en) wr_cnt++;
            if (done) done_cyc = cyc;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (stalled && (!m_valid || m_data !== held_d || m_last !== held_l)) stable_err++;
            if (m_valid && m_ready) begin
                got.push_back(m_data); got_last.push_back(m_last); stalled = 0;
            end else if (m_valid) begin
                stalled = 1; held_d = m_data; held_l = m_last;
            end else begin
                stalled = 0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        #1 idle_busy = int'(busy);
    endtask

    task automatic load_basic();
        mem[11'h010] = 16'h0100; mem[11'h011] = 16'hFF00;
        mem[11'h012] = 16'h7FFF; mem[11'h013] = 16'h0001;
    endtask

    task automatic check_basic_words(input string tag);
        check({tag, "_n"},  got.size(), 4);
        check({tag, "_w0"}, got_at(0), {16'h0, exp_word(16'h0100)});
        check({tag, "_w1"}, got_at(1), {16'h0, exp_word(16'hFF00)});
        check({tag, "_w2"}, got_at(2), {16'h0, exp_word(16'h7FFF)});
        check({tag, "_w3"}, got_at(3), {16'h0, exp_word(16'h0001)});
        check({tag, "_nlast"}, last_count(), 1);
        check({tag, "_last3"}, (got_last.size() == 4) ? {31'h0, got_last[3]} : 32'hDEAD_BEEF, 1);
        check({tag, "_done"}, (done_cyc >= 0), 1);
        check({tag, "_wr"}, wr_cnt, 0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h5A5A;
        load_basic();
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; clear = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_wren",  bram_wr_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last",  m_last, 0);
        check("rst_addr",  bram_addr, 0);
        rst = 1'b0;

        // Basic drain, ready held high
        drain(11'h010, 12'd4, 1'b0, 0, 1'b0);
        check_basic_words("basic");
        check("basic_first_c3", first_valid, 3);
        check("basic_done_c7",  done_cyc, 7);
        check("basic_idle",     idle_busy, 0);
        check("basic_mem11",    mem[11'h011], 16'hFF00);
        check("basic_mem13",    mem[11'h013], 16'h0001);

        // Backpressure plus an ignored mid-drain start
        drain(11'h010, 12'd4, 1'b0, 1, 1'b1);
        check_basic_words("bp");
        check("bp_stable", stable_err, 0);
        check("bp_mem7fe", mem[11'h7FE], 16'h5A5A);

        // Clear-on-read with address wrap
        mem[11'h7FE] = 16'h1234; mem[11'h7FF] = 16'h8001;
        mem[11'h000] = 16'h00FF; mem[11'h001] = 16'hABCD;
        drain(11'h7FE, 12'd4, 1'b1, 0, 1'b0);
        check("clr_n",  got.size(), 4);
        check("clr_w0", got_at(0), {16'h0, exp_word(16'h1234)});
        check("clr_w1", got_at(1), {16'h0, exp_word(16'h8001)});
        check("clr_w2", got_at(2), {16'h0, exp_word(16'h00FF)});
        check("clr_w3", got_at(3), {16'h0, exp_word(16'hABCD)});
        check("clr_wr", wr_cnt, 4);
        check("clr_m7fe", mem[11'h7FE], 0);
        check("clr_m7ff", mem[11'h7FF], 0);
        check("clr_m000", mem[11'h000], 0);
        check("clr_m001", mem[11'h001], 0);
        check("clr_m002", mem[11'h002], 16'h5A5A);

        // Zero count
        drain(11'h010, 12'd0, 1'b1, 0, 1'b0);
        check("zero_done_c1", done_cyc, 1);
        check("zero_novalid", first_valid, -1);
        check("zero_wr",      wr_cnt, 0);
        check("zero_idle",    idle_busy, 0);

        // Reset with two words buffered
        @(negedge clk);
        m_ready = 1'b0; base_addr = 11'h010; count = 12'd4; clear = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("rstmid_pre_valid", m_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid_valid", m_valid, 0);
        check("rstmid_busy",  busy, 0);
        check("rstmid_last",  m_last, 0);
        rst = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid_nodone",  done, 0);
        check("rstmid_valid2",  m_valid, 0);
        drain(11'h010, 12'd4, 1'b0, 0, 1'b0);
        check_basic_words("post");
        check("post_first_c3", first_valid, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
